// File: rtl/word_to_bit_serializer_pkg.sv
// rtl/word_to_bit_serializer_pkg.sv - shared state type and counter width for the word-to-bit serializer
package serializer_pkg;
   typedef enum logic {IDLE, SHIFT} ser_state_t;
   localparam int WORDS_SENT_W = 16;
endpackage

// File: rtl/word_to_bit_serializer_if.sv
// rtl/word_to_bit_serializer_if.sv - word input handshake plus serial bit output and status
interface word_to_bit_serializer_if #(parameter int WIDTH = 8);
   import serializer_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        in_data;
   logic                    bit_out;
   logic                    bit_valid;
   logic                    busy;
   logic [WORDS_SENT_W-1:0] words_sent;

   modport master (
      output in_valid, in_data,
      input  in_ready, bit_out, bit_valid, busy, words_sent
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, bit_out, bit_valid, busy, words_sent
   );
endinterface

// File: rtl/word_to_bit_serializer_fifo.sv
// rtl/word_to_bit_serializer_fifo.sv - small word FIFO feeding the serializer shift register
module serializer_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push_ok;
   logic             w_pop_ok;

   // Extra pointer MSB separates full from empty when the index bits match.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end
endmodule

// File: rtl/word_to_bit_serializer.sv
// rtl/word_to_bit_serializer.sv - buffers parallel words and shifts them out one bit per clock
module word_to_bit_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 2,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input logic                     clk,
   input logic                     rst,
   word_to_bit_serializer_if.slave bus
);
   localparam int            CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   ser_state_t               r_state;
   ser_state_t               w_state_nxt;
   logic [WIDTH-1:0]         r_shift;
   logic [WIDTH-1:0]         w_shift_nxt;
   logic [CNT_W-1:0]         r_bit_cnt;
   logic [CNT_W-1:0]         w_bit_cnt_nxt;
   logic                     r_bit_out;
   logic                     w_bit_out_nxt;
   logic [WORDS_SENT_W-1:0]  r_words_sent;
   logic                     w_word_done;
   logic                     w_pop;
   logic                     w_push;
   logic                     w_fifo_full;
   logic                     w_fifo_empty;
   logic [WIDTH-1:0]         w_fifo_data;

   function automatic logic head_bit(input logic [WIDTH-1:0] word);
      return MSB_FIRST ? word[WIDTH-1] : word[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
      return MSB_FIRST ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
   endfunction

   assign w_push = bus.in_valid & ~w_fifo_full;

   serializer_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (bus.in_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_cnt_nxt = r_bit_cnt;
      w_pop         = 1'b0;
      w_word_done   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!w_fifo_empty) begin
               w_pop         = 1'b1;
               w_shift_nxt   = w_fifo_data;
               w_bit_cnt_nxt = '0;
               w_state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            if (r_bit_cnt == LAST_BIT) begin
               w_word_done = 1'b1;
               // Pop straight into the shifter so adjacent words stay contiguous.
               if (!w_fifo_empty) begin
                  w_pop         = 1'b1;
                  w_shift_nxt   = w_fifo_data;
                  w_bit_cnt_nxt = '0;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_shift_nxt   = advance(r_shift);
               w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      w_bit_out_nxt = (w_state_nxt == SHIFT) ? head_bit(w_shift_nxt) : IDLE_BIT;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_bit_out    <= IDLE_BIT;
         r_words_sent <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_bit_out <= w_bit_out_nxt;
         if (w_word_done) r_words_sent <= r_words_sent + 1'b1;
      end
   end

   assign bus.in_ready   = ~w_fifo_full;
   assign bus.bit_out    = r_bit_out;
   assign bus.bit_valid  = (r_state == SHIFT);
   assign bus.busy       = (r_state == SHIFT) | ~w_fifo_empty;
   assign bus.words_sent = r_words_sent;
endmodule

// File: tb/tb_word_to_bit_serializer.sv
// tb/tb_word_to_bit_serializer.sv - bench for word_to_bit_serializer against a bit-queue model
module tb_word_to_bit_serializer;
   import serializer_pkg::*;

   localparam int W = 8;
   localparam int D = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   word_to_bit_serializer_if #(.WIDTH(W)) bm ();
   word_to_bit_serializer_if #(.WIDTH(W)) bl ();

   word_to_bit_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
      .clk (clk), .rst (rst), .bus (bm.slave));
   word_to_bit_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
      .clk (clk), .rst (rst), .bus (bl.slave));

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   // Model: expected bit stream in emission order, words accepted, and what has been observed.
   bit exp_q[$];
   int acc = 0;
   int bits_seen = 0;
   int started = 0;
   int prev_occ = 0;
   bit seen_q[$];
   int seen_cyc[$];
   bit cmp_valid;
   bit cmp_bit;
   int cmp_occ;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: bound expired or model empty", name);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_bit_valid", bm.bit_valid, 0);
         chk("rst_bit_out", bm.bit_out, 0);
         chk("rst_busy", bm.busy, 0);
         chk("rst_words_sent", bm.words_sent, 0);
         chk("rst_in_ready", bm.in_ready, 1);
         bits_seen = 0;
         started   = 0;
         prev_occ  = 0;
         seen_q.delete();
         seen_cyc.delete();
      end else begin
         // A word is mid-flight, or one was waiting in the FIFO before this cycle's edge.
         cmp_valid = (bits_seen % W != 0) || (prev_occ > 0);
         chk("bit_valid", bm.bit_valid, cmp_valid);
         chk("words_sent", bm.words_sent, (bits_seen / W) % 65536);
         if (cmp_valid) begin
            if (bits_seen % W == 0) started++;
            if (exp_q.size() == 0) begin
               fail("model_underflow");
            end else begin
               cmp_bit = exp_q.pop_front();
               chk("bit_out", bm.bit_out, cmp_bit);
            end
            seen_q.push_back(bm.bit_out);
            seen_cyc.push_back(cyc);
            bits_seen++;
         end else begin
            chk("idle_bit_out", bm.bit_out, 0);
         end
         cmp_occ = acc - started;
         chk("in_ready", bm.in_ready, cmp_occ < D);
         chk("busy", bm.busy, cmp_valid || (cmp_occ > 0));
         prev_occ = cmp_occ;
      end
   end

   int stall = 0;

   task automatic push_word(input logic [W-1:0] d);
      int n = 0;
      bm.in_valid = 1'b1;
      bm.in_data  = d;
      while (!bm.in_ready && n < 50) begin
         @(negedge clk); #1;
         n++;
         stall++;
      end
      if (!bm.in_ready) fail("push_timeout");
      @(posedge clk); #1;
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
      acc++;
   endtask

   task automatic idle(input int n);
      bm.in_valid = 1'b0;
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bm.in_valid = 1'b0;
      bl.in_valid = 1'b0;
      exp_q.delete();
      acc = 0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic wait_bits(input int target, input int budget, input string name);
      int n = 0;
      while (bits_seen < target && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (bits_seen < target) fail(name);
   endtask

   function automatic logic [31:0] seen_value(input int nbits);
      logic [31:0] v = '0;
      for (int i = 0; i < nbits && i < seen_q.size(); i++) v = {v[30:0], seen_q[i]};
      return v;
   endfunction

   int acc_cyc;
   int det_cnt;
   int det_k;
   logic [5:0] det_sh;
   logic [7:0] lv;
   int lcnt;

   initial begin
      bm.in_valid = 1'b0; bm.in_data = '0;
      bl.in_valid = 1'b0; bl.in_data = '0;

      do_reset();
      idle(2);
      chk("init_words_sent", bm.words_sent, 0);
      chk("init_in_ready", bm.in_ready, 1);

      // Single word, MSB first
      push_word(8'hA5);
      acc_cyc = cyc;
      bm.in_valid = 1'b0;
      wait_bits(8, 40, "single_wait");
      idle(3);
      chk("single_bits", seen_value(8), 32'h0000_00A5);
      chk("single_count", seen_q.size(), 8);
      if (seen_q.size() == 8) begin
         chk("single_first_latency", seen_cyc[0] - acc_cyc, 1);
         chk("single_last_latency", seen_cyc[7] - acc_cyc, 8);
      end
      chk("single_words_sent", bm.words_sent, 1);
      chk("single_busy_low", bm.busy, 0);

      // Back-to-back words form one contiguous 16-bit stream
      do_reset();
      push_word(8'hCC);
      push_word(8'hCF);
      bm.in_valid = 1'b0;
      wait_bits(16, 60, "b2b_wait");
      idle(3);
      chk("b2b_bits", seen_value(16), 32'h0000_CCCF);
      if (seen_q.size() == 16) chk("b2b_no_gap", seen_cyc[15] - seen_cyc[0], 15);
      det_cnt = 0; det_k = 0; det_sh = '0;
      for (int i = 0; i < seen_q.size(); i++) begin
         det_sh = {det_sh[4:0], seen_q[i]};
         det_k++;
         if (det_k >= 6 && det_sh == 6'b110011) begin
            det_cnt++;
            det_k  = 0;
            det_sh = '0;
         end
      end
      chk("b2b_detector_hits", det_cnt, 2);
      chk("b2b_words_sent", bm.words_sent, 2);

      // Full backpressure: four words with in_valid held high
      do_reset();
      stall = 0;
      push_word(8'h3C);
      push_word(8'h81);
      push_word(8'hF0);
      push_word(8'h5A);
      bm.in_valid = 1'b0;
      wait_bits(32, 200, "bp_wait");
      idle(3);
      chk("bp_ready_dropped", stall > 0, 1);
      chk("bp_bits", seen_value(32), 32'h3C81_F05A);
      chk("bp_words_sent", bm.words_sent, 4);

      // LSB-first instance
      do_reset();
      chk("lsb_ready", bl.in_ready, 1);
      bl.in_valid = 1'b1;
      bl.in_data  = 8'h01;
      @(posedge clk); #1;
      bl.in_valid = 1'b0;
      lv = '0; lcnt = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (bl.bit_valid) begin
            lv = {lv[6:0], bl.bit_out};
            lcnt++;
         end
      end
      #1;
      chk("lsb_bits", lv, 8'b1000_0000);
      chk("lsb_count", lcnt, 8);
      chk("lsb_words_sent", bl.words_sent, 1);

      // Reset during bit 3 of the first word with a second word buffered
      do_reset();
      push_word(8'hFF);
      push_word(8'h96);
      bm.in_valid = 1'b0;
      wait_bits(4, 20, "midrst_wait");
      rst = 1'b0;
      exp_q.delete();
      acc = 0;
      #1;
      chk("midrst_bit_valid", bm.bit_valid, 0);
      chk("midrst_bit_out", bm.bit_out, 0);
      chk("midrst_words_sent", bm.words_sent, 0);
      chk("midrst_in_ready", bm.in_ready, 1);
      chk("midrst_busy", bm.busy, 0);
      @(negedge clk); #1 rst = 1'b1;
      idle(20);
      chk("midrst_silent", seen_q.size(), 0);
      chk("midrst_count_after", bm.words_sent, 0);
      push_word(8'h0F);
      bm.in_valid = 1'b0;
      wait_bits(8, 40, "midrst_resume_wait");
      idle(3);
      chk("midrst_resume_bits", seen_value(8), 32'h0000_000F);
      chk("midrst_resume_count", bm.words_sent, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
